// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with device ACK check
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 1_000_000 * 120,
  parameter int START_TIMEOUT  = CLK_FREQ_HZ / 1_000 * 15,
  parameter int FRAME_TIMEOUT  = CLK_FREQ_HZ / 1_000 * 2,
  parameter int FILTER_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err_noack,
  output logic       err_timeout
);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [20:0] INH_LAST   = 21'(INHIBIT_CYCLES - 1);
  localparam logic [20:0] START_LAST = 21'(START_TIMEOUT - 1);
  localparam logic [20:0] FRAME_LAST = 21'(FRAME_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_ACK_SAMPLE, S_WAIT_IDLE, S_FINISH
  } state_t;

  state_t state, next;
  logic clk_s1, clk_s2, data_s1, data_s2, clk_filt, fall;
  logic [FW-1:0] filt_cnt;
  logic [20:0] cnt, frame_cnt;
  logic [9:0] shift;
  logic [3:0] bit_idx;
  logic res_ack, res_noack, res_to;
  logic frame_expired, timeout_hit;

  assign frame_expired = (frame_cnt == FRAME_LAST);

  // Synchronizers idle high like the released bus; fall pulses with the filtered 1->0 change.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
      fall    <= 1'b0;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
        fall     <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  always_comb begin
    next        = state;
    tx_ready    = 1'b0;
    busy        = 1'b1;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    done        = 1'b0;
    ack_ok      = 1'b0;
    err_noack   = 1'b0;
    err_timeout = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        if (tx_valid) next = S_INHIBIT;
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt == INH_LAST) begin
          ps2_data_oe = 1'b1;
          next        = S_REQ;
        end
      end
      S_REQ: begin
        ps2_data_oe = 1'b1;
        if (fall) next = S_SEND;
        else if (cnt == START_LAST) begin
          next        = S_FINISH;
          timeout_hit = 1'b1;
        end
      end
      S_SEND: begin
        ps2_data_oe = ~shift[0];
        if (frame_expired) begin
          next        = S_FINISH;
          timeout_hit = 1'b1;
        end else if (fall && bit_idx == 4'd9) next = S_ACK;
      end
      S_ACK: begin
        if (frame_expired) begin
          next        = S_FINISH;
          timeout_hit = 1'b1;
        end else if (fall) next = S_ACK_SAMPLE;
      end
      S_ACK_SAMPLE: begin
        if (frame_expired) begin
          next        = S_FINISH;
          timeout_hit = 1'b1;
        end else next = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (frame_expired) begin
          next        = S_FINISH;
          timeout_hit = 1'b1;
        end else if (clk_filt && data_s2) next = S_FINISH;
      end
      S_FINISH: begin
        done        = 1'b1;
        ack_ok      = res_ack;
        err_noack   = res_noack;
        err_timeout = res_to;
        next        = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  // shift[0] is the bit on the wire; {stop, parity, data} shifts out LSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      frame_cnt <= '0;
      shift     <= '0;
      bit_idx   <= '0;
      res_ack   <= 1'b0;
      res_noack <= 1'b0;
      res_to    <= 1'b0;
    end else begin
      cnt       <= (next != state) ? 21'd0 : ((cnt == '1) ? cnt : cnt + 21'd1);
      frame_cnt <= (state == S_REQ && next == S_SEND) ? 21'd0 :
                   ((frame_cnt == '1) ? frame_cnt : frame_cnt + 21'd1);
      if (state == S_IDLE && tx_valid) begin
        shift     <= {1'b1, ~^tx_data, tx_data};
        res_ack   <= 1'b0;
        res_noack <= 1'b0;
        res_to    <= 1'b0;
      end
      if (state == S_REQ) bit_idx <= 4'd1;
      if (state == S_SEND && fall && !frame_expired) begin
        shift   <= {1'b0, shift[9:1]};
        bit_idx <= bit_idx + 4'd1;
      end
      if (timeout_hit) begin
        res_to    <= 1'b1;
        res_ack   <= 1'b0;
        res_noack <= 1'b0;
      end else if (state == S_ACK_SAMPLE) begin
        res_ack   <= ~data_s2;
        res_noack <= data_s2;
      end
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
  localparam int INH   = 200;
  localparam int START = 3000;
  localparam int FRAME = 4000;
  localparam int HP    = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic dev_clk = 1'b1, dev_data = 1'b1;
  logic tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, err_noack, err_timeout;
  logic clk_line, data_line;

  assign clk_line  = dev_clk & ~ps2_clk_oe;
  assign data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .CLK_FREQ_HZ(100_000_000), .INHIBIT_CYCLES(INH), .START_TIMEOUT(START),
    .FRAME_TIMEOUT(FRAME), .FILTER_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .ps2_clk_in(clk_line), .ps2_data_in(data_line), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .ack_ok(ack_ok),
    .err_noack(err_noack), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ack, noack, to, chk_frame, chk_time;
    logic [10:0] frame;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, failures = 0;
  int cyc = 0, req_cyc = 0, done_cnt = 0, run = 0, last_run = 0;
  logic prev_clk_oe = 1'b0;
  logic [10:0] dev_frame = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b, input logic par);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic push_exp(input logic a, input logic n, input logic t, input logic cf,
                          input logic [10:0] f, input logic ct);
    exp_t e;
    e.ack = a; e.noack = n; e.to = t; e.chk_frame = cf; e.frame = f; e.chk_time = ct;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the expected result of each transaction when done pulses.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (prev_clk_oe && !ps2_clk_oe) req_cyc = cyc;
    prev_clk_oe = ps2_clk_oe;
    if (ps2_clk_oe) run++;
    else if (run > 0) begin
      last_run = run;
      run = 0;
    end
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("ack_ok", 32'(ack_ok), 32'(e.ack));
        chk("err_noack", 32'(err_noack), 32'(e.noack));
        chk("err_timeout", 32'(err_timeout), 32'(e.to));
        chk("oe_at_done", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        if (e.chk_frame) chk("device_frame", 32'(dev_frame), 32'(e.frame));
        if (e.chk_time) chk("start_timeout_latency", 32'(cyc - req_cyc), 32'(START));
      end
    end
  end

  task automatic start_tx(input logic [7:0] b);
    int w = 0;
    while (!tx_ready && w < 10000) begin tick; w++; end
    chk("tx_ready_wait", 32'(tx_ready), 32'd1);
    tx_valid = 1'b1;
    tx_data  = b;
    tick;
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int w = 0;
    while (done_cnt < n && w < 10000) begin tick; w++; end
    chk("done_wait", 32'(done_cnt >= n), 32'd1);
    repeat (3) tick;
  endtask

  task automatic device(input logic do_ack, input int glitch_at, input int stop_after);
    int w = 0;
    while (!(clk_line && !data_line && !ps2_clk_oe) && w < 5000) begin tick; w++; end
    if (w >= 5000) begin
      chk("device_request_seen", 32'd0, 32'd1);
      return;
    end
    dev_frame = '0;
    for (int i = 0; i < 11; i++) begin
      if (i == glitch_at) begin
        repeat (10) tick;
        dev_clk = 1'b0;
        repeat (5) tick;
        dev_clk = 1'b1;
        repeat (HP - 15) tick;
      end else repeat (HP) tick;
      dev_frame[i] = data_line;
      dev_clk = 1'b0;
      if (i == 10 && do_ack) dev_data = 1'b0;
      repeat (HP) tick;
      if (i == stop_after) return;
      dev_clk = 1'b1;
    end
    repeat (HP) tick;
    dev_data = 1'b1;
  endtask

  initial begin
    repeat (3) tick;
    chk("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("reset_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_flags", {28'd0, done, ack_ok, err_noack, err_timeout}, 32'd0);
    chk("reset_tx_ready", 32'(tx_ready), 32'd1);
    rst = 1'b0;
    repeat (20) tick;

    // 0xED: odd parity 1; inhibit length checked too
    push_exp(1, 0, 0, 1, frame_of(8'hED, 1'b1), 0);
    start_tx(8'hED);
    device(1, -1, -1);
    wait_done(1);
    chk("inhibit_cycles", 32'(last_run), 32'(INH));

    push_exp(1, 0, 0, 1, frame_of(8'h00, 1'b1), 0);
    start_tx(8'h00);
    device(1, -1, -1);
    wait_done(2);
    push_exp(1, 0, 0, 1, frame_of(8'h01, 1'b0), 0);
    start_tx(8'h01);
    device(1, -1, -1);
    wait_done(3);
    push_exp(1, 0, 0, 1, frame_of(8'hFF, 1'b1), 0);
    start_tx(8'hFF);
    device(1, -1, -1);
    wait_done(4);

    // silent device: start timeout
    push_exp(0, 0, 1, 0, 11'd0, 1);
    start_tx(8'h12);
    wait_done(5);

    // no ACK from device
    push_exp(0, 1, 0, 1, frame_of(8'hF4, 1'b0), 0);
    start_tx(8'hF4);
    device(0, -1, -1);
    wait_done(6);

    // reset while D4 of 0xA5 (D4=0) is on the wire
    start_tx(8'hA5);
    device(1, -1, 4);
    chk("d4_presented", 32'(ps2_data_oe), 32'd1);
    rst = 1'b1;
    tick;
    chk("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    dev_clk = 1'b1;
    repeat (100) tick;
    chk("no_done_after_rst", 32'(done_cnt), 32'd6);

    // request held while busy plus a clock glitch mid-frame
    push_exp(1, 0, 0, 1, frame_of(8'h3C, 1'b1), 0);
    push_exp(1, 0, 0, 1, frame_of(8'h55, 1'b1), 0);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    tick;
    tx_data  = 8'h55;
    device(1, 4, -1);
    begin
      int w = 0;
      while (!tx_ready && w < 2000) begin tick; w++; end
    end
    chk("second_accept_after_done", 32'(done_cnt), 32'd7);
    tick;
    tx_valid = 1'b0;
    device(1, -1, -1);
    wait_done(8);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'd8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
